// File: rtl/sw_symbol_conditioner.sv
// Switch front end: synchronise and debounce four symbol switches, reject
// multi-switch presses, and present each accepted press once via valid/ack.
module sw_symbol_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_in,
    input  logic       sym_ack,
    output logic       sym_valid,
    output logic       sym_x,
    output logic       sym_y,
    output logic       sym_err,
    output logic       busy
);

    // Handshake: sym_valid rises with sym_x/sym_y already stable and all three
    // stay frozen until the edge where sym_ack=1 is seen; that edge drops
    // sym_valid. sym_ack is ignored whenever sym_valid=0.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       cand;
    logic [3:0]       stable;
    logic [CNT_W-1:0] cnt;
    logic             one_hot;
    logic             multi;
    logic             valid_d;
    logic             x_d;
    logic             y_d;
    logic             err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 4'd0;
            s2     <= 4'd0;
            cand   <= 4'd0;
            stable <= 4'd0;
            cnt    <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                stable <= cand;
            end
        end
    end

    // A single set bit is a legal press; anything more is a chord.
    assign one_hot = (stable != 4'd0) && ((stable & (stable - 4'd1)) == 4'd0);
    assign multi   = (stable != 4'd0) && !one_hot;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sym_valid <= 1'b0;
            sym_x     <= 1'b0;
            sym_y     <= 1'b0;
            sym_err   <= 1'b0;
        end else begin
            state     <= next_state;
            sym_valid <= valid_d;
            sym_x     <= x_d;
            sym_y     <= y_d;
            sym_err   <= err_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    next_state = VALID;
                end else if (multi) begin
                    next_state = HOLD;
                end
            end
            VALID: begin
                if (sym_ack) begin
                    next_state = (stable != 4'd0) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (stable == 4'd0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        valid_d = sym_valid;
        x_d     = sym_x;
        y_d     = sym_y;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    valid_d = 1'b1;
                    x_d     = stable[3] | stable[2];
                    y_d     = stable[1] | stable[3];
                end else if (multi) begin
                    err_d = 1'b1;
                end
            end
            VALID: begin
                if (sym_ack) begin
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sw_symbol_conditioner.sv
// Bench for sw_symbol_conditioner: directed scenarios then random switch
// activity, checked every cycle against a sample-history reference model.
module tb_sw_symbol_conditioner;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_in;
    logic       sym_ack;
    logic       sym_valid;
    logic       sym_x;
    logic       sym_y;
    logic       sym_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rise  = 0;
    int n_errp  = 0;

    sw_symbol_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(20)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_in    (sw_in),
        .sym_ack  (sym_ack),
        .sym_valid(sym_valid),
        .sym_x    (sym_x),
        .sym_y    (sym_y),
        .sym_err  (sym_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: the debounced value is whatever the synchronised input
    // has shown for N+1 consecutive samples; presses are tracked as events.
    logic [3:0] pipe_q[$];
    logic [3:0] hist_q[$];
    logic [1:0] exp_q[$];
    logic [3:0] m_stable;
    logic       m_valid, m_x, m_y, m_err, m_locked;
    logic       prev_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [3:0] d;
        logic [1:0] code;
        bit         same;
        if (reset) begin
            pipe_q = '{4'd0, 4'd0};
            hist_q = '{4'd0};
            m_stable = 4'd0;
            m_valid = 0; m_x = 0; m_y = 0; m_err = 0; m_locked = 0;
            exp_q.delete();
            return;
        end
        m_err = 0;
        if (m_valid) begin
            if (sym_ack) begin
                m_valid  = 0;
                m_locked = (m_stable != 4'd0);
            end
        end else if (m_locked) begin
            if (m_stable == 4'd0) m_locked = 0;
        end else if ($countones(m_stable) == 1) begin
            code = 2'd0;
            for (int i = 0; i < 4; i++) if (m_stable[i]) code = 2'(i);
            m_x = code[1];
            m_y = code[0];
            m_valid = 1;
            exp_q.push_back(code);
        end else if ($countones(m_stable) > 1) begin
            m_err    = 1;
            m_locked = 1;
        end
        d = pipe_q.pop_front();
        pipe_q.push_back(sw_in);
        hist_q.push_back(d);
        if (hist_q.size() > N + 1) void'(hist_q.pop_front());
        if (hist_q.size() == N + 1) begin
            same = 1;
            foreach (hist_q[i]) if (hist_q[i] != d) same = 0;
            if (same) m_stable = d;
        end
    endtask

    task automatic check_all();
        logic [1:0] e;
        check("sym_valid", 32'(sym_valid), 32'(m_valid));
        check("sym_x", 32'(sym_x), 32'(m_x));
        check("sym_y", 32'(sym_y), 32'(m_y));
        check("sym_err", 32'(sym_err), 32'(m_err));
        check("busy", 32'(busy), 32'(m_valid | m_locked));
        if (sym_err) n_errp++;
        if (sym_valid && !prev_valid) begin
            n_rise++;
            check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_symbol", 32'({sym_x, sym_y}), 32'(e));
            end
        end
        prev_valid = sym_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic [3:0] sw, input logic ack, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            sw_in   = sw;
            sym_ack = ack;
            tick();
        end
    endtask

    initial begin
        int rise0, err0;
        logic [3:0] pat;
        int r;
        prev_valid = 0;
        reset = 1; sw_in = 4'd0; sym_ack = 0;
        @(negedge clk);
        drive(4'd0, 0, 2);
        check("reset_valid", 32'(sym_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 0;
        drive(4'd0, 0, 10);

        // Clean step 0010: valid exactly at edge k+7, then held without ack.
        drive(4'b0010, 0, 7);
        check("lat_before", 32'(sym_valid), 32'd0);
        drive(4'b0010, 0, 1);
        check("lat_at", 32'(sym_valid), 32'd1);
        check("lat_xy", 32'({sym_x, sym_y}), 32'b01);
        drive(4'b0010, 0, 20);
        check("held_valid", 32'(sym_valid), 32'd1);
        drive(4'b0010, 1, 1);
        check("ack_drop", 32'(sym_valid), 32'd0);
        check("ack_hold_busy", 32'(busy), 32'd1);
        drive(4'b0010, 0, 5);
        check("hold_busy", 32'(busy), 32'd1);
        drive(4'd0, 0, 10);
        check("release_idle", 32'(busy), 32'd0);

        // Short glitch is rejected, a 6-cycle press is accepted.
        rise0 = n_rise; err0 = n_errp;
        drive(4'b1000, 0, 3);
        drive(4'd0, 0, 12);
        check("glitch_rise", 32'(n_rise - rise0), 32'd0);
        check("glitch_err", 32'(n_errp - err0), 32'd0);
        drive(4'b1000, 0, 6);
        drive(4'd0, 0, 10);
        check("press6_valid", 32'(sym_valid), 32'd1);
        check("press6_xy", 32'({sym_x, sym_y}), 32'b11);
        drive(4'd0, 1, 1);
        drive(4'd0, 0, 3);

        // Chord gives one error pulse and no symbol.
        rise0 = n_rise; err0 = n_errp;
        drive(4'b0110, 0, 12);
        check("chord_err", 32'(n_errp - err0), 32'd1);
        check("chord_rise", 32'(n_rise - rise0), 32'd0);
        drive(4'd0, 0, 10);
        drive(4'b0100, 0, 10);
        check("after_chord_xy", 32'({sym_valid, sym_x, sym_y}), 32'b110);
        drive(4'b0100, 1, 1);
        drive(4'd0, 0, 10);

        // Long hold yields one symbol; adding a switch does nothing.
        rise0 = n_rise;
        drive(4'b0001, 0, 10);
        drive(4'b0001, 1, 1);
        drive(4'b0001, 0, 50);
        check("long_hold_rises", 32'(n_rise - rise0), 32'd1);
        rise0 = n_rise; err0 = n_errp;
        drive(4'b0011, 0, 20);
        check("added_rise", 32'(n_rise - rise0), 32'd0);
        check("added_err", 32'(n_errp - err0), 32'd0);
        drive(4'd0, 0, 10);
        drive(4'b0001, 0, 10);
        check("repress_xy", 32'({sym_valid, sym_x, sym_y}), 32'b100);
        drive(4'b0001, 1, 1);
        drive(4'd0, 0, 10);

        // Release before ack keeps the symbol; ack returns straight to idle.
        drive(4'b0100, 0, 8);
        drive(4'd0, 0, 10);
        check("rel_keep", 32'({sym_valid, sym_x, sym_y}), 32'b110);
        drive(4'd0, 1, 1);
        check("rel_ack_idle", 32'({sym_valid, busy}), 32'b00);

        // Reset while presenting a symbol, switch still held.
        drive(4'b0010, 0, 10);
        reset = 1;
        drive(4'b0010, 0, 1);
        check("rst_outs", 32'({sym_valid, sym_x, sym_y, sym_err, busy}), 32'd0);
        reset = 0;
        drive(4'b0010, 0, N + 3);
        check("rst_relat_before", 32'(sym_valid), 32'd0);
        drive(4'b0010, 0, 1);
        check("rst_relat_xy", 32'({sym_valid, sym_x, sym_y}), 32'b101);
        drive(4'b0010, 1, 1);
        drive(4'd0, 0, 10);

        // Random switch activity with random ack and occasional reset.
        for (int seg = 0; seg < 250; seg++) begin
            r = $urandom_range(0, 9);
            if (r < 5) pat = 4'(1 << $urandom_range(0, 3));
            else if (r < 7) pat = 4'(3 << $urandom_range(0, 2)) | 4'($urandom_range(0, 15));
            else if (r < 9) pat = 4'd0;
            else pat = 4'($urandom_range(0, 15));
            for (int c = 0, len = $urandom_range(1, 12); c < len; c++) begin
                reset = ($urandom_range(0, 299) == 0);
                drive(pat, ($urandom_range(0, 3) == 0), 1);
            end
        end
        reset = 0;
        drive(4'd0, 0, 12);
        drive(4'd0, 1, 2);
        drive(4'd0, 0, 2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
